// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares the single RAM port between instruction fetch (IF) and load/store (DP).
// Arbitrates in IDLE, rejects misaligned or reserved-size requests without
// touching the RAM, runs a SETUP/ACCESS cycle pair on the MOV/MOC handshake,
// and reports done/err back to whichever requester was granted.
module ram_access_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int TIMEOUT  = 15,
    parameter int DP_BURST = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic          if_err,
    output logic [DW-1:0] if_rdata,
    input  logic          dp_req,
    input  logic          dp_we,
    input  logic [1:0]    dp_dt,
    input  logic [AW-1:0] dp_addr,
    input  logic [DW-1:0] dp_wdata,
    output logic          dp_done,
    output logic          dp_err,
    output logic [DW-1:0] dp_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_rw,
    output logic          ram_mov,
    output logic [1:0]    ram_dt,
    input  logic          ram_moc,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    localparam logic [7:0] BURST_LIM = 8'(DP_BURST);
    localparam logic [7:0] TMO_LIM   = 8'(TIMEOUT);
    localparam logic [1:0] DT_WORD   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_ACCESS   = 3'd2,
        S_COMPLETE = 3'd3,
        S_ERROR    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [7:0]    burst_q, burst_d;
    logic          gnt_dp_q, gnt_dp_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          rw_q, rw_d;
    logic [1:0]    dt_q, dt_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dp_rdata_q, dp_rdata_d;

    logic          any_req;
    logic          pick_dp;
    logic [AW-1:0] win_addr;
    logic [1:0]    win_dt;
    logic          win_ok;
    logic [7:0]    timer_inc;

    // Size/alignment legality: halfwords even, words on 4-byte boundaries, dt=11 never.
    function automatic logic is_aligned(input logic [1:0] dt, input logic [1:0] lsb);
        case (dt)
            2'b00:   return 1'b1;
            2'b01:   return ~lsb[0];
            2'b10:   return (lsb == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Pick this cycle's winner: DP has priority until it has won DP_BURST times in a row over a waiting IF.
    always_comb begin
        any_req   = if_req | dp_req;
        pick_dp   = dp_req & (~if_req | (burst_q != BURST_LIM));
        win_addr  = pick_dp ? dp_addr : if_addr;
        win_dt    = pick_dp ? dp_dt : DT_WORD;
        win_ok    = is_aligned(win_dt, win_addr[1:0]);
        timer_inc = timer_q + 8'd1;
    end

    // State register; clr drops everything (including MOV) immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the access sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = win_ok ? S_SETUP : S_ERROR;
                end
            end
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (ram_moc) begin
                    state_d = S_COMPLETE;
                end else if (timer_inc == TMO_LIM) begin
                    state_d = S_ERROR;
                end
            end
            S_COMPLETE: state_d = S_IDLE;
            S_ERROR:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Next values for the MAR/MDR latches, read-data registers, MOC timer and burst counter.
    always_comb begin
        timer_d    = timer_q;
        burst_d    = burst_q;
        gnt_dp_d   = gnt_dp_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rw_d       = rw_q;
        dt_d       = dt_q;
        if_rdata_d = if_rdata_q;
        dp_rdata_d = dp_rdata_q;

        if (state_q == S_IDLE && any_req) begin
            gnt_dp_d = pick_dp;
            // Only a DP grant that kept IF waiting extends the burst.
            if (pick_dp && if_req) begin
                burst_d = burst_q + 8'd1;
            end else begin
                burst_d = '0;
            end
            // Illegal requests never reach the RAM, so the bus latches keep their old values.
            if (win_ok) begin
                addr_d = win_addr;
                din_d  = pick_dp ? dp_wdata : '0;
                rw_d   = ~(pick_dp & dp_we);
                dt_d   = win_dt;
            end
        end else if (!if_req) begin
            burst_d = '0;
        end

        if (state_q == S_SETUP) begin
            timer_d = '0;
        end

        if (state_q == S_ACCESS) begin
            timer_d = timer_inc;
            // Captured on MOC so the value is already visible while done pulses.
            if (ram_moc && rw_q) begin
                if (gnt_dp_q) begin
                    dp_rdata_d = ram_dout;
                end else begin
                    if_rdata_d = ram_dout;
                end
            end
        end
    end

    // Datapath and bookkeeping registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            timer_q    <= '0;
            burst_q    <= '0;
            gnt_dp_q   <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            rw_q       <= 1'b1;
            dt_q       <= '0;
            if_rdata_q <= '0;
            dp_rdata_q <= '0;
        end else begin
            timer_q    <= timer_d;
            burst_q    <= burst_d;
            gnt_dp_q   <= gnt_dp_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rw_q       <= rw_d;
            dt_q       <= dt_d;
            if_rdata_q <= if_rdata_d;
            dp_rdata_q <= dp_rdata_d;
        end
    end

    // Strobes and status decoded from the state, steered to the granted port.
    always_comb begin
        ram_mov = (state_q == S_ACCESS);
        busy    = (state_q != S_IDLE);
        if_done = (state_q == S_COMPLETE) & ~gnt_dp_q;
        dp_done = (state_q == S_COMPLETE) &  gnt_dp_q;
        if_err  = (state_q == S_ERROR)    & ~gnt_dp_q;
        dp_err  = (state_q == S_ERROR)    &  gnt_dp_q;
    end

    assign ram_addr = addr_q;
    assign ram_din  = din_q;
    assign ram_rw   = rw_q;
    assign ram_dt   = dt_q;
    assign if_rdata = if_rdata_q;
    assign dp_rdata = dp_rdata_q;

endmodule
